synth_spi_regfile: RTL and testbench

Parametrised SPI control front-end for the multi-oscillator synthesiser. Receives byte-framed register writes from the host MCU over a mode-0 SPI slave link, assembles multi-byte values per channel into shadow registers, and transfers all shadow values to the active oscillator controls atomically when the host sends a commit ("kick") byte. Sits between the SPI pins and the oscillator/amplitude datapath; replaces the single-oscillator, fixed-width decoder.

---
 rtl/synth_spi_regfile.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_synth_spi_regfile.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/synth_spi_regfile.sv
// -----------------------------------------------------------------------------
// synth_spi_regfile
//
// SPI (mode 0) control front-end for the multi-oscillator synthesiser.
// The host writes byte-framed register values per channel. The values are
// assembled into shadow registers. All shadows are copied to the active
// oscillator controls in a single cycle when a kick byte (0x00) arrives.
//
// Optional feature macro: SYNTH_SPI_READBACK_EN
//   When defined, a header with bit 7 set reads back the addressed channel's
//   active register on MISO. When undefined, MISO always echoes the previous
//   received byte.
//
// Ports
//   i_clk50mhz  system clock
//   i_rst_n     asynchronous active-low reset
//   i_spi_clk   SPI SCLK, idle low, asynchronous to i_clk50mhz
//   i_spi_mosi  SPI data in, MSB first
//   i_spi_ss    SPI slave select, active low
//   o_spi_miso  SPI data out, changes on SCLK falling edge
//   o_wave      active waveform selects, channel c at [c*WAVE_W +: WAVE_W]
//   o_freq      active frequency words, same packing
//   o_amp       active amplitudes, same packing
//   o_commit    one-cycle pulse when a kick is applied
//
// Byte handshake (internal): byte_vld_q is a one-cycle strobe that qualifies
// byte_q. There is no back-pressure. The FSM consumes every strobed byte in
// the cycle that the strobe is high.
// -----------------------------------------------------------------------------
module synth_spi_regfile #(
    parameter int N_CH   = 4,
    parameter int FREQ_W = 24,
    parameter int AMP_W  = 16,
    parameter int WAVE_W = 3
) (
    input  logic                     i_clk50mhz,
    input  logic                     i_rst_n,
    input  logic                     i_spi_clk,
    input  logic                     i_spi_mosi,
    input  logic                     i_spi_ss,
    output logic                     o_spi_miso,
    output logic [N_CH*WAVE_W-1:0]   o_wave,
    output logic [N_CH*FREQ_W-1:0]   o_freq,
    output logic [N_CH*AMP_W-1:0]    o_amp,
    output logic                     o_commit
);

    localparam int         ASM_W      = (FREQ_W > AMP_W) ? FREQ_W : AMP_W;
    localparam logic [3:0] REG_WAVE   = 4'h1;
    localparam logic [3:0] REG_FREQ   = 4'h2;
    localparam logic [3:0] REG_AMP    = 4'h4;
    localparam logic [2:0] FREQ_BYTES = 3'(FREQ_W / 8);
    localparam logic [2:0] AMP_BYTES  = 3'(AMP_W / 8);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WDATA = 2'd1,
        ST_RDATA = 2'd2
    } state_t;

    // ---------------- SPI byte layer ----------------
    // sclk_sync: [0] first stage, [1] second stage, [2] previous second stage
    logic [2:0] sclk_sync_q, sclk_sync_d;
    logic [1:0] mosi_sync_q, mosi_sync_d;
    logic [1:0] ss_sync_q,   ss_sync_d;
    logic [2:0] bit_cnt_q,   bit_cnt_d;
    logic [6:0] rx_sh_q,     rx_sh_d;
    logic       byte_vld_q,  byte_vld_d;
    logic [7:0] byte_q,      byte_d;
    logic [7:0] last_q,      last_d;
    logic [7:0] tx_sh_q,     tx_sh_d;
    logic [7:0] tx_byte;
    logic       sclk_rise, sclk_fall, ss_act, mosi_s;

    // ---------------- register FSM ----------------
    state_t                  state_q,   state_d;
    logic [2:0]              ch_q,      ch_d;
    logic [3:0]              reg_q,     reg_d;
    logic [2:0]              rem_q,     rem_d;
    logic [ASM_W-1:0]        asm_q,     asm_d;
    logic [N_CH*WAVE_W-1:0]  sh_wave_q, sh_wave_d;
    logic [N_CH*FREQ_W-1:0]  sh_freq_q, sh_freq_d;
    logic [N_CH*AMP_W-1:0]   sh_amp_q,  sh_amp_d;
    logic [N_CH*WAVE_W-1:0]  wave_q,    wave_d;
    logic [N_CH*FREQ_W-1:0]  freq_q,    freq_d;
    logic [N_CH*AMP_W-1:0]   amp_q,     amp_d;
    logic                    commit_q,  commit_d;
    logic [2:0]              hdr_bytes;
    logic [ASM_W-1:0]        wr_val;
    logic                    ch_ok;
    int                      ch_idx;

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign ss_act    = ~ss_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];

    assign ch_ok  = (int'(ch_q) < N_CH);
    assign ch_idx = ch_ok ? int'(ch_q) : 0;
    assign wr_val = (asm_q << 8) | ASM_W'(byte_q);

`ifdef SYNTH_SPI_READBACK_EN
    logic [ASM_W-1:0] rd_val;
    logic [ASM_W-1:0] rd_shift;
    logic [7:0]       rd_byte;

    // Readback returns the active value, MSB byte first, indexed by the
    // remaining byte count.
    always_comb begin
        rd_val = '0;
        if (ch_ok) begin
            case (reg_q)
                REG_WAVE: rd_val = ASM_W'(wave_q[ch_idx*WAVE_W +: WAVE_W]);
                REG_FREQ: rd_val = ASM_W'(freq_q[ch_idx*FREQ_W +: FREQ_W]);
                REG_AMP:  rd_val = ASM_W'(amp_q[ch_idx*AMP_W +: AMP_W]);
                default:  rd_val = '0;
            endcase
        end
        rd_shift = rd_val >> {rem_q - 3'd1, 3'b000};
        rd_byte  = rd_shift[7:0];
    end

    always_comb begin
        tx_byte = last_q;
        if (state_q == ST_RDATA) tx_byte = rd_byte;
    end
`else
    always_comb begin
        tx_byte = last_q;
    end
`endif

    always_comb begin
        case (byte_q[3:0])
            REG_WAVE: hdr_bytes = 3'd1;
            REG_FREQ: hdr_bytes = FREQ_BYTES;
            REG_AMP:  hdr_bytes = AMP_BYTES;
            default:  hdr_bytes = 3'd0;
        endcase
    end

    // SPI bit/byte layer
    always_comb begin
        sclk_sync_d = {sclk_sync_q[1], sclk_sync_q[0], i_spi_clk};
        mosi_sync_d = {mosi_sync_q[0], i_spi_mosi};
        ss_sync_d   = {ss_sync_q[0], i_spi_ss};
        bit_cnt_d   = bit_cnt_q;
        rx_sh_d     = rx_sh_q;
        byte_vld_d  = 1'b0;
        byte_d      = byte_q;
        last_d      = last_q;
        tx_sh_d     = tx_sh_q;

        if (!ss_act) begin
            bit_cnt_d = 3'd0;
        end else if (sclk_rise) begin
            rx_sh_d = {rx_sh_q[5:0], mosi_s};
            if (bit_cnt_q == 3'd7) begin
                byte_vld_d = 1'b1;
                byte_d     = {rx_sh_q, mosi_s};
                bit_cnt_d  = 3'd0;
            end else begin
                bit_cnt_d = bit_cnt_q + 3'd1;
            end
        end

        if (byte_vld_q) last_d = byte_q;

        // Between bytes the transmit register keeps reloading. This lets it
        // pick up the echo or readback byte after the FSM has reacted to
        // the previous byte. The host's first rising edge is many clocks
        // away at that point.
        if (bit_cnt_q == 3'd0) begin
            tx_sh_d = tx_byte;
        end else if (sclk_fall && ss_act) begin
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
        end
    end

    // Register FSM
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        reg_d     = reg_q;
        rem_d     = rem_q;
        asm_d     = asm_q;
        sh_wave_d = sh_wave_q;
        sh_freq_d = sh_freq_q;
        sh_amp_d  = sh_amp_q;
        wave_d    = wave_q;
        freq_d    = freq_q;
        amp_d     = amp_q;
        commit_d  = 1'b0;

        if (byte_vld_q) begin
            case (state_q)
                ST_IDLE: begin
                    if (byte_q == 8'h00) begin
                        wave_d   = sh_wave_q;
                        freq_d   = sh_freq_q;
                        amp_d    = sh_amp_q;
                        commit_d = 1'b1;
                    end else if (byte_q[7]) begin
`ifdef SYNTH_SPI_READBACK_EN
                        state_d = ST_RDATA;
                        ch_d    = byte_q[6:4];
                        reg_d   = byte_q[3:0];
                        // An unknown register still takes one byte, which reads as 0x00.
                        rem_d   = (hdr_bytes != 3'd0) ? hdr_bytes : 3'd1;
`endif
                    end else if (hdr_bytes != 3'd0) begin
                        state_d = ST_WDATA;
                        ch_d    = byte_q[6:4];
                        reg_d   = byte_q[3:0];
                        rem_d   = hdr_bytes;
                        asm_d   = '0;
                    end
                end
                ST_WDATA: begin
                    asm_d = wr_val;
                    if (rem_q == 3'd1) begin
                        state_d = ST_IDLE;
                        if (ch_ok) begin
                            case (reg_q)
                                REG_WAVE: sh_wave_d[ch_idx*WAVE_W +: WAVE_W] = wr_val[WAVE_W-1:0];
                                REG_FREQ: sh_freq_d[ch_idx*FREQ_W +: FREQ_W] = wr_val[FREQ_W-1:0];
                                REG_AMP:  sh_amp_d[ch_idx*AMP_W +: AMP_W]    = wr_val[AMP_W-1:0];
                                default:  ;
                            endcase
                        end
                    end else begin
                        rem_d = rem_q - 3'd1;
                    end
                end
                ST_RDATA: begin
                    if (rem_q == 3'd1) state_d = ST_IDLE;
                    else               rem_d   = rem_q - 3'd1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk50mhz or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ss_sync_q   <= 2'b11;
            bit_cnt_q   <= '0;
            rx_sh_q     <= '0;
            byte_vld_q  <= 1'b0;
            byte_q      <= '0;
            last_q      <= '0;
            tx_sh_q     <= '0;
            state_q     <= ST_IDLE;
            ch_q        <= '0;
            reg_q       <= '0;
            rem_q       <= '0;
            asm_q       <= '0;
            sh_wave_q   <= '0;
            sh_freq_q   <= '0;
            sh_amp_q    <= '0;
            wave_q      <= '0;
            freq_q      <= '0;
            amp_q       <= '0;
            commit_q    <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            ss_sync_q   <= ss_sync_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sh_q     <= rx_sh_d;
            byte_vld_q  <= byte_vld_d;
            byte_q      <= byte_d;
            last_q      <= last_d;
            tx_sh_q     <= tx_sh_d;
            state_q     <= state_d;
            ch_q        <= ch_d;
            reg_q       <= reg_d;
            rem_q       <= rem_d;
            asm_q       <= asm_d;
            sh_wave_q   <= sh_wave_d;
            sh_freq_q   <= sh_freq_d;
            sh_amp_q    <= sh_amp_d;
            wave_q      <= wave_d;
            freq_q      <= freq_d;
            amp_q       <= amp_d;
            commit_q    <= commit_d;
        end
    end

    assign o_spi_miso = tx_sh_q[7];
    assign o_wave     = wave_q;
    assign o_freq     = freq_q;
    assign o_amp      = amp_q;
    assign o_commit   = commit_q;

endmodule

// File: tb/tb_synth_spi_regfile.sv
// -----------------------------------------------------------------------------
// tb_synth_spi_regfile
//
// Directed bench for synth_spi_regfile with the default parameters
// (4 channels, 24-bit freq, 16-bit amp, 3-bit wave). It acts as an SPI
// mode-0 master, with each SCLK phase lasting 6 system clocks. All expected
// values are written out by hand.
// -----------------------------------------------------------------------------
module tb_synth_spi_regfile;

  localparam int HALF = 6;

  logic        clk;
  logic        rst_n;
  logic        sclk;
  logic        mosi;
  logic        ss;
  logic        miso;
  logic [11:0] wave;
  logic [95:0] freq;
  logic [63:0] amp;
  logic        commit;

  int          n_cmp;
  int          n_fail;
  int          commit_cnt;
  logic [7:0]  rx_byte;

  synth_spi_regfile #(
    .N_CH(4), .FREQ_W(24), .AMP_W(16), .WAVE_W(3)
  ) dut (
    .i_clk50mhz (clk),
    .i_rst_n    (rst_n),
    .i_spi_clk  (sclk),
    .i_spi_mosi (mosi),
    .i_spi_ss   (ss),
    .o_spi_miso (miso),
    .o_wave     (wave),
    .o_freq     (freq),
    .o_amp      (amp),
    .o_commit   (commit)
  );

  // clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (commit === 1'b1) commit_cnt <= commit_cnt + 1;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Drives one byte and leaves SCLK high after the 8th rising edge.
  task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
    ss = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      repeat (HALF) @(negedge clk);
      sclk  = 1'b1;
      rx[i] = miso;
      if (i > 0) begin
        repeat (HALF) @(negedge clk);
        sclk = 1'b0;
      end
    end
  endtask

  task automatic close_frame();
    repeat (HALF) @(negedge clk);
    sclk = 1'b0;
    repeat (4) @(negedge clk);
    ss = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    xfer(b, rx_byte);
    close_frame();
  endtask

  // Four bits clocked in, then SS released.
  task automatic send_partial(input logic [3:0] bits);
    ss = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 3; i >= 0; i--) begin
      mosi = bits[i];
      repeat (HALF) @(negedge clk);
      sclk = 1'b1;
      repeat (HALF) @(negedge clk);
      sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
    ss = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    commit_cnt = 0;
    rst_n      = 1'b0;
    sclk       = 1'b0;
    mosi       = 1'b0;
    ss         = 1'b1;

    // reset state
    repeat (5) @(negedge clk);
    check("rst_wave", wave, 0);
    check("rst_freq", freq, 0);
    check("rst_amp", amp, 0);
    check("rst_commit", commit, 0);
    check("rst_miso", miso, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("post_rst_miso", miso, 0);

    // wave write ch0 = 5, then a timed kick
    send(8'h01);
    check("echo_after_rst", rx_byte, 8'h00);
    send(8'h05);
    check("echo_01", rx_byte, 8'h01);
    check("wave_before_kick", wave, 0);
    xfer(8'h00, rx_byte);
    check("echo_05", rx_byte, 8'h05);
    repeat (3) @(negedge clk);
    check("kick_commit_early", commit, 0);
    check("kick_wave_early", wave, 0);
    @(negedge clk);
    check("kick_commit", commit, 1);
    check("kick_wave", wave, 12'h005);
    @(negedge clk);
    check("kick_commit_drop", commit, 0);
    close_frame();
    check("commit_count_1", commit_cnt, 1);

    // freq write ch0 = 0xFFFF03
    send(8'h02);
    send(8'hFF);
    send(8'hFF);
    send(8'h03);
    check("freq_shadow_only", freq, 0);
    send(8'h00);
    check("freq_ch0", freq, 96'h000000_000000_000000_FFFF03);
    check("wave_kept", wave, 12'h005);
    check("commit_count_2", commit_cnt, 2);

    // amp write ch2 = 0x7FFF
    send(8'h24);
    send(8'h7F);
    send(8'hFF);
    send(8'h00);
    check("amp_ch2", amp, 64'h0000_7FFF_0000_0000);
    check("amp_ch0_unchanged", amp[15:0], 16'h0000);

    // wave ch1 with upper bits set: 0xFE keeps 3'b110
    send(8'h11);
    send(8'hFE);
    send(8'h00);
    check("wave_ch1_trunc", wave, 12'h035);

    // channel 7 does not exist: data consumed, nothing written
    send(8'h74);
    send(8'h12);
    send(8'h34);
    send(8'h00);
    check("ch7_amp", amp, 64'h0000_7FFF_0000_0000);
    check("ch7_freq", freq, 96'h000000_000000_000000_FFFF03);
    check("ch7_wave", wave, 12'h035);
    check("commit_count_5", commit_cnt, 5);

    // freq ch3 with an aborted partial byte after the header
    send(8'h32);
    send_partial(4'b1010);
    send(8'hAA);
    send(8'hBB);
    check("echo_AA", rx_byte, 8'hAA);
    send(8'hCC);
    check("echo_BB", rx_byte, 8'hBB);
    send(8'h00);
    check("echo_CC", rx_byte, 8'hCC);
    check("freq_ch3", freq, 96'hAABBCC_000000_000000_FFFF03);

`ifdef SYNTH_SPI_READBACK_EN
    // readback of ch0 freq, active value
    send(8'h82);
    send(8'h55);
    check("rd_byte0", rx_byte, 8'hFF);
    send(8'h55);
    check("rd_byte1", rx_byte, 8'hFF);
    send(8'h55);
    check("rd_byte2", rx_byte, 8'h03);
    check("rd_freq_kept", freq, 96'hAABBCC_000000_000000_FFFF03);
    check("rd_commit_count", commit_cnt, 6);
    // back in IDLE: echo again
    send(8'h00);
    check("rd_then_echo", rx_byte, 8'h55);
`else
    // read header ignored; MISO keeps echoing
    send(8'h82);
    send(8'h55);
    check("no_rd_echo", rx_byte, 8'h82);
    check("no_rd_freq_kept", freq, 96'hAABBCC_000000_000000_FFFF03);
    check("no_rd_commit_count", commit_cnt, 6);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
